// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side packer: defaults, lane limits,
// lane state encoding and small width/mask helpers.
package fifo_pkg;

    localparam int unsigned DSIZE_DEF = 8;
    localparam int unsigned LANES_MIN = 2;
    localparam int unsigned LANES_MAX = 8;
    localparam int unsigned CNT_MAX_W = $clog2(LANES_MAX + 1);

    typedef enum logic [1:0] {
        StEmpty,
        StPartial,
        StFull
    } lane_state_e;

    // A zero-width timer is not representable, so a disabled timeout still gets one bit.
    function automatic int unsigned timer_width(input int unsigned tmo);
        return (tmo < 1) ? 1 : $clog2(tmo + 1);
    endfunction

    function automatic logic [LANES_MAX-1:0] keep_mask(input logic [CNT_MAX_W-1:0] cnt);
        logic [LANES_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < LANES_MAX; i++) begin
            m[i] = (CNT_MAX_W'(i) < cnt);
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_out_reg.sv
// Valid/ready output holding register: loads a word, holds it under
// backpressure and drops valid once accepted.
module fifo_out_reg #(
    parameter int unsigned DW = 32,
    parameter int unsigned KW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic [KW-1:0] load_keep,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic [KW-1:0] keep
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            keep  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            keep  <= load_keep;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-domain packer: pops FIFO entries into a LANES-wide accumulator and
// emits full words, or partial words on flush or idle timeout.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF,
    parameter int unsigned LANES = 4,
    parameter int unsigned TMO   = 16
) (
    input  logic                   rclk,
    input  logic                   rrst,
    input  logic                   rempty,
    input  logic [DSIZE-1:0]       rdata,
    output logic                   rinc,
    input  logic                   flush,
    output logic [DSIZE*LANES-1:0] m_data,
    output logic [LANES-1:0]       m_keep,
    output logic                   m_valid,
    input  logic                   m_ready
);

    localparam int unsigned CW = $clog2(LANES + 1);
    localparam int unsigned TW = timer_width(TMO);
    localparam logic [CW-1:0] LANES_C = CW'(LANES);
    localparam logic [TW-1:0] TMO_C   = TW'(TMO);

    if ((LANES < LANES_MIN) || (LANES > LANES_MAX)) begin : g_bad_lanes
        $error("fifo_rd_packer: LANES out of range");
    end

    logic [LANES-1:0][DSIZE-1:0] acc_q, acc_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [TW-1:0]               timer_q, timer_d;

    lane_state_e          state;
    logic                 slot_free;
    logic                 tmo_hit;
    logic                 req;
    logic                 load;
    logic [LANES_MAX-1:0] keep_full;
    logic [LANES-1:0]     load_keep;
    logic                 unused_keep;

    always_comb begin
        if (cnt_q == '0) begin
            state = StEmpty;
        end else if (cnt_q == LANES_C) begin
            state = StFull;
        end else begin
            state = StPartial;
        end
    end

    assign slot_free = !m_valid || m_ready;
    assign tmo_hit   = (TMO != 0) && (timer_q == TMO_C);
    assign req       = (state == StFull) || ((state == StPartial) && (flush || tmo_hit));
    assign load      = req && slot_free;
    // A full accumulator may still pop when it is being unloaded this same cycle.
    assign rinc      = !rempty && ((state != StFull) || load);

    assign keep_full   = keep_mask(CNT_MAX_W'(cnt_q));
    assign load_keep   = keep_full[LANES-1:0];
    assign unused_keep = ^keep_full;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (load) begin
            // Clearing on unload keeps unused lanes of later partial words at zero.
            acc_d = '0;
            cnt_d = '0;
            if (rinc) begin
                acc_d[0] = rdata;
                cnt_d    = CW'(1);
            end
        end else if (rinc) begin
            for (int i = 0; i < LANES; i++) begin
                if (cnt_q == CW'(i)) begin
                    acc_d[i] = rdata;
                end
            end
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_comb begin
        timer_d = timer_q;
        if (rinc || load || (state == StEmpty)) begin
            timer_d = '0;
        end else if ((state == StPartial) && (timer_q != TMO_C)) begin
            timer_d = timer_q + TW'(1);
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
        end
    end

    fifo_out_reg #(
        .DW(DSIZE * LANES),
        .KW(LANES)
    ) u_out_reg (
        .clk       (rclk),
        .rst       (rrst),
        .load      (load),
        .load_data (acc_q),
        .load_keep (load_keep),
        .ready     (m_ready),
        .valid     (m_valid),
        .data      (m_data),
        .keep      (m_keep)
    );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed and scoreboard bench for fifo_rd_packer with a behavioural FWFT FIFO.
module tb_fifo_rd_packer;

    logic        rclk = 1'b0;
    logic        rrst;
    logic        rempty;
    logic [7:0]  rdata;
    logic        rinc;
    logic        flush;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_valid;
    logic        m_ready;

    always #5 rclk = ~rclk;

    fifo_rd_packer #(
        .DSIZE(8),
        .LANES(4),
        .TMO  (16)
    ) dut (
        .rclk    (rclk),
        .rrst    (rrst),
        .rempty  (rempty),
        .rdata   (rdata),
        .rinc    (rinc),
        .flush   (flush),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        int          cyc;
    } beat_t;

    typedef struct {
        int          n;
        logic [7:0]  base;
        logic        fl;
        logic [31:0] exp_data;
        logic [3:0]  exp_keep;
        int          exp_cyc;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [7:0]  fq[$];
    beat_t       got[$];
    logic [7:0]  ent[$];
    logic        s_valid, s_rinc, s_rempty;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    vec_t        vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_fifo();
        rempty = (fq.size() == 0);
        rdata  = rempty ? 8'h00 : fq[0];
    endtask

    task automatic push(input logic [7:0] v);
        fq.push_back(v);
        drive_fifo();
    endtask

    // Sample at the falling edge, then retire the pop just after the rising edge.
    task automatic tick();
        @(negedge rclk);
        s_valid  = m_valid;
        s_data   = m_data;
        s_keep   = m_keep;
        s_rinc   = rinc;
        s_rempty = rempty;
        if (s_rempty) chk("rinc_while_empty", {31'd0, s_rinc}, 32'd0);
        if (s_valid && m_ready) got.push_back('{s_data, s_keep, cyc});
        @(posedge rclk);
        #1;
        if (s_rinc && fq.size() > 0) void'(fq.pop_front());
        drive_fifo();
        cyc++;
    endtask

    task automatic check_beat(input string name, input int idx, input logic [31:0] d,
                              input logic [3:0] k, input int c);
        if (got.size() > idx) begin
            chk({name, "_data"}, got[idx].data, d);
            chk({name, "_keep"}, {28'd0, got[idx].keep}, {28'd0, k});
            chk({name, "_cyc"}, got[idx].cyc, c);
        end
    endtask

    initial begin
        vecs[0] = '{3, 8'h01, 1'b1, 32'h0003_0201, 4'h7, 4};
        vecs[1] = '{1, 8'h5A, 1'b1, 32'h0000_005A, 4'h1, 2};
        vecs[2] = '{4, 8'hC0, 1'b0, 32'hC3C2_C1C0, 4'hF, 5};
        vecs[3] = '{2, 8'hE0, 1'b0, 32'h0000_E1E0, 4'h3, 19};
        vecs[4] = '{0, 8'h00, 1'b1, 32'h0, 4'h0, 0};

        rrst    = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b1;
        drive_fifo();
        #1;
        chk("reset_valid", {31'd0, m_valid}, 32'd0);
        chk("reset_data", m_data, 32'd0);
        chk("reset_keep", {28'd0, m_keep}, 32'd0);
        chk("reset_rinc", {31'd0, rinc}, 32'd0);
        repeat (2) @(posedge rclk);
        #1;
        rrst = 1'b0;

        // Continuous stream, two full words.
        got.delete();
        cyc = 0;
        for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("cont_rinc", {31'd0, s_rinc}, (i < 8) ? 32'd1 : 32'd0);
        end
        chk("cont_beats", got.size(), 2);
        check_beat("cont_b0", 0, 32'h4433_2211, 4'hF, 5);
        check_beat("cont_b1", 1, 32'h8877_6655, 4'hF, 9);

        // Backpressure: first word held, accumulator fills, pops stop with data waiting.
        got.delete();
        cyc = 0;
        m_ready = 1'b0;
        for (int i = 1; i <= 9; i++) push(8'(i * 8'h11));
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 5 || i == 11) begin
                chk("bp_valid", {31'd0, s_valid}, 32'd1);
                chk("bp_data", s_data, 32'h4433_2211);
                chk("bp_keep", {28'd0, s_keep}, 32'hF);
            end
        end
        chk("bp_rinc_low", {31'd0, s_rinc}, 32'd0);
        chk("bp_rempty_low", {31'd0, s_rempty}, 32'd0);
        m_ready = 1'b1;
        tick();
        tick();
        flush = 1'b1;
        tick();
        tick();
        tick();
        flush = 1'b0;
        chk("bp_beats", got.size(), 3);
        check_beat("bp_b0", 0, 32'h4433_2211, 4'hF, 12);
        check_beat("bp_b1", 1, 32'h8877_6655, 4'hF, 13);
        check_beat("bp_b2", 2, 32'h0000_0099, 4'h1, 15);

        // Idle timeout on a two-entry partial word; no repeat afterwards.
        got.delete();
        cyc = 0;
        push(8'hAA);
        push(8'hBB);
        for (int i = 0; i < 26; i++) tick();
        chk("tmo_beats", got.size(), 1);
        check_beat("tmo_b0", 0, 32'h0000_BBAA, 4'h3, 19);

        // Table: flush-driven, full and timeout words, and flush on an empty accumulator.
        foreach (vecs[v]) begin
            got.delete();
            cyc = 0;
            for (int i = 0; i < vecs[v].n; i++) push(vecs[v].base + 8'(i));
            for (int i = 0; i < vecs[v].n; i++) tick();
            flush = vecs[v].fl;
            for (int i = 0; i < 30; i++) tick();
            flush = 1'b0;
            for (int i = 0; i < 3; i++) tick();
            chk($sformatf("vec%0d_beats", v), got.size(), (vecs[v].exp_keep != 0) ? 1 : 0);
            if (vecs[v].exp_keep != 0) begin
                check_beat($sformatf("vec%0d", v), 0, vecs[v].exp_data, vecs[v].exp_keep,
                           vecs[v].exp_cyc);
            end
        end

        // Asynchronous reset with a held word and a partial accumulator.
        got.delete();
        cyc = 0;
        m_ready = 1'b0;
        for (int i = 1; i <= 7; i++) push(8'(i * 8'h11));
        for (int i = 0; i < 12; i++) tick();
        chk("rst_pre_valid", {31'd0, s_valid}, 32'd1);
        #1;
        rrst = 1'b1;
        #1;
        chk("rst_async_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_async_data", m_data, 32'd0);
        chk("rst_async_keep", {28'd0, m_keep}, 32'd0);
        #1;
        rrst = 1'b0;
        fq.delete();
        drive_fifo();
        m_ready = 1'b1;
        got.delete();
        cyc = 0;
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
        for (int i = 0; i < 15; i++) tick();
        chk("rst_beats", got.size(), 1);
        check_beat("rst_b0", 0, 32'h1312_1110, 4'hF, 5);

        // Random data, always ready: back-to-back words with a pop every cycle.
        got.delete();
        ent.delete();
        cyc = 0;
        for (int i = 0; i < 64; i++) begin
            ent.push_back(8'($urandom_range(0, 255)));
            push(ent[i]);
        end
        for (int i = 0; i < 74; i++) begin
            tick();
            chk("s1_no_bubble", {31'd0, s_rinc}, {31'd0, !s_rempty});
        end
        chk("s1_beats", got.size(), 16);
        for (int b = 0; b < 16 && b < got.size(); b++) begin
            chk("s1_data", got[b].data, {ent[4*b+3], ent[4*b+2], ent[4*b+1], ent[4*b]});
            chk("s1_cyc", got[b].cyc, 5 + 4 * b);
        end

        // Random data, random ready.
        got.delete();
        ent.delete();
        cyc = 0;
        for (int i = 0; i < 64; i++) begin
            ent.push_back(8'($urandom_range(0, 255)));
            push(ent[i]);
        end
        for (int n = 0; n < 3000 && got.size() < 16; n++) begin
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        m_ready = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        chk("s2_beats", got.size(), 16);
        for (int b = 0; b < 16 && b < got.size(); b++) begin
            chk("s2_data", got[b].data, {ent[4*b+3], ent[4*b+2], ent[4*b+1], ent[4*b]});
            chk("s2_keep", {28'd0, got[b].keep}, 32'hF);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
